// File: rtl/velocity_pkg.sv
// Shared constants and helpers for the velocity estimator slice.
package velocity_pkg;

    localparam int unsigned VEL_AVG_LOG2_MAX   = 4;
    localparam int unsigned VEL_COEF_DEFAULT   = 29;
    localparam int unsigned VEL_COEF_W_DEFAULT = 8;
    localparam int unsigned VEL_FRAC_DEFAULT   = 3;

    typedef enum logic {
        PRIME_WAIT = 1'b0,
        PRIME_DONE = 1'b1
    } prime_e;

    // Clip val to an unsigned width-bit maximum, flagging when clipping happened.
    function automatic logic [63:0] vel_clip(input logic [63:0] val, input int unsigned width,
                                             output logic sat);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        sat   = (val > max_v);
        return sat ? max_v : val;
    endfunction

endpackage

// File: rtl/velocity_estimator_moving_avg.sv
// Power-of-two moving average over a register ring buffer; LOG2 = 0 degenerates to a register.
module moving_avg_pow2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign o_valid = valid_q;
    assign o_data  = data_q;

    if (LOG2 == 0) begin : g_bypass
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (i_flush) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= i_valid;
                if (i_valid) data_q <= i_data;
            end
        end
    end else begin : g_avg
        localparam int unsigned DEPTH = 2 ** LOG2;
        localparam int unsigned SUM_W = DATA_W + LOG2;

        logic [DATA_W-1:0] ring_q [DEPTH];
        logic [LOG2-1:0]   ptr_q;
        logic [SUM_W-1:0]  sum_q;
        logic [SUM_W-1:0]  sum_d;

        // ptr_q points at the oldest entry, which the incoming sample replaces.
        always_comb begin
            sum_d = sum_q + SUM_W'(i_data) - SUM_W'(ring_q[ptr_q]);
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ptr_q   <= '0;
                sum_q   <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            end else if (i_flush) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ptr_q   <= '0;
                sum_q   <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            end else begin
                valid_q <= i_valid;
                if (i_valid) begin
                    ring_q[ptr_q] <= i_data;
                    ptr_q         <= ptr_q + LOG2'(1);
                    sum_q         <= sum_d;
                    data_q        <= sum_d[SUM_W-1:LOG2];
                end
            end
        end
    end

endmodule

// File: rtl/velocity_estimator.sv
// Velocity estimator: primed |delta| with direction, fixed-point scale, saturate, moving average.
module velocity_estimator
    import velocity_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned COEF     = VEL_COEF_DEFAULT,
    parameter int unsigned COEF_W   = VEL_COEF_W_DEFAULT,
    parameter int unsigned FRAC     = VEL_FRAC_DEFAULT,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_value,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_value,
    output logic             o_dir,
    output logic             o_sat
);

    localparam int unsigned PROD_W = IN_W + COEF_W;

    prime_e             prime_q;
    logic [IN_W-1:0]    prev_q;
    logic               dir_q;
    logic               s1_valid_q;
    logic [IN_W-1:0]    s1_diff_q;
    logic [IN_W-1:0]    diff_d;
    logic               s2_valid_q;
    logic [OUT_W-1:0]   s2_scaled_q;
    logic               s2_dir_q;
    logic               s2_sat_q;
    logic [PROD_W-1:0]  prod_d;
    logic [PROD_W-1:0]  shifted_d;
    logic [63:0]        clip_d;
    logic               sat_d;
    logic               s3_dir_q;
    logic               s3_sat_q;
    logic               avg_valid;
    logic [OUT_W-1:0]   avg_data;
    logic               o_valid_q;
    logic [OUT_W-1:0]   o_value_q;
    logic               o_dir_q;
    logic               o_sat_q;

    always_comb begin
        diff_d    = (i_value > prev_q) ? (i_value - prev_q) : (prev_q - i_value);
        prod_d    = PROD_W'(s1_diff_q) * PROD_W'(COEF);
        shifted_d = prod_d >> FRAC;
        clip_d    = vel_clip(64'(shifted_d), OUT_W, sat_d);
    end

    // Direction on the stage-2 edge is taken from dir_q, which still reflects the sample in stage 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_flush) begin
            prime_q     <= PRIME_WAIT;
            prev_q      <= '0;
            dir_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_scaled_q <= '0;
            s2_dir_q    <= 1'b0;
            s2_sat_q    <= 1'b0;
            s3_dir_q    <= 1'b0;
            s3_sat_q    <= 1'b0;
            o_valid_q   <= 1'b0;
            o_value_q   <= '0;
            o_dir_q     <= 1'b0;
            o_sat_q     <= 1'b0;
        end else begin
            s1_valid_q <= 1'b0;
            if (i_valid) begin
                prev_q <= i_value;
                if (prime_q == PRIME_WAIT) begin
                    prime_q <= PRIME_DONE;
                end else begin
                    s1_valid_q <= 1'b1;
                    s1_diff_q  <= diff_d;
                    if (i_value != prev_q) dir_q <= (i_value > prev_q);
                end
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_scaled_q <= clip_d[OUT_W-1:0];
                s2_sat_q    <= sat_d;
                s2_dir_q    <= dir_q;
            end
            if (s2_valid_q) begin
                s3_dir_q <= s2_dir_q;
                s3_sat_q <= s2_sat_q;
            end
            o_valid_q <= avg_valid;
            if (avg_valid) begin
                o_value_q <= avg_data;
                o_dir_q   <= s3_dir_q;
                o_sat_q   <= s3_sat_q;
            end
        end
    end

    moving_avg_pow2 #(
        .DATA_W (OUT_W),
        .LOG2   (AVG_LOG2)
    ) u_avg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (s2_valid_q),
        .i_data  (s2_scaled_q),
        .o_valid (avg_valid),
        .o_data  (avg_data)
    );

    assign o_valid = o_valid_q;
    assign o_value = o_value_q;
    assign o_dir   = o_dir_q;
    assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_velocity_estimator.sv
// Drives a bypass (AVG_LOG2=0) and a 4-tap (AVG_LOG2=2) estimator with shared stimulus against a reference model.
module tb_velocity_estimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic [15:0] value;

    logic        ov0, od0, os0, ov2, od2, os2;
    logic [15:0] oval0, oval2;

    always #5 clk = ~clk;

    velocity_estimator #(.AVG_LOG2(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .i_value(value),
        .o_valid(ov0), .o_value(oval0), .o_dir(od0), .o_sat(os0)
    );

    velocity_estimator #(.AVG_LOG2(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .i_value(value),
        .o_valid(ov2), .o_value(oval2), .o_dir(od2), .o_sat(os2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: sample history, window averages, outputs scheduled 3 edges ahead.
    int  k = 0;
    bit  m_primed;
    int  m_prev;
    bit  m_dir;
    int  hist[$];
    bit  pend_v   [8];
    int  pend_val [2][8];
    bit  pend_dir [8];
    bit  pend_sat [8];
    int  last_val [2];
    bit  last_dir;
    bit  last_sat;
    int  win [2] = '{1, 4};
    string nm [2] = '{"L0", "L2"};

    function automatic int exp_avg(input int w);
        int s = 0;
        for (int i = 0; i < w && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
        return s / w;
    endfunction

    task automatic model_reset();
        m_primed = 0;
        m_prev   = 0;
        m_dir    = 0;
        hist.delete();
        for (int i = 0; i < 8; i++) pend_v[i] = 0;
        last_val = '{0, 0};
        last_dir = 0;
        last_sat = 0;
    endtask

    task automatic compare_outputs(input bit exp_v);
        check({nm[0], "_valid"}, 32'(ov0), 32'(exp_v));
        check({nm[0], "_value"}, 32'(oval0), 32'(last_val[0]));
        check({nm[0], "_dir"}, 32'(od0), 32'(last_dir));
        check({nm[0], "_sat"}, 32'(os0), 32'(last_sat));
        check({nm[1], "_valid"}, 32'(ov2), 32'(exp_v));
        check({nm[1], "_value"}, 32'(oval2), 32'(last_val[1]));
        check({nm[1], "_dir"}, 32'(od2), 32'(last_dir));
        check({nm[1], "_sat"}, 32'(os2), 32'(last_sat));
    endtask

    task automatic model_edge(input bit v, input int val, input bit fl);
        int  s;
        bit  exp_v;
        int  diff;
        int  scaled;
        bit  sat;
        s = k % 8;
        exp_v = 0;
        if (fl) begin
            model_reset();
        end else if (pend_v[s]) begin
            exp_v = 1;
            for (int d = 0; d < 2; d++) last_val[d] = pend_val[d][s];
            last_dir = pend_dir[s];
            last_sat = pend_sat[s];
        end
        compare_outputs(exp_v);
        pend_v[s] = 0;
        if (!fl && v) begin
            if (!m_primed) begin
                m_primed = 1;
            end else begin
                diff   = (val > m_prev) ? val - m_prev : m_prev - val;
                if (val != m_prev) m_dir = (val > m_prev);
                scaled = (diff * 29) / 8;
                sat    = scaled > 65535;
                if (sat) scaled = 65535;
                hist.push_back(scaled);
                if (hist.size() > 16) void'(hist.pop_front());
                s = (k + 3) % 8;
                pend_v[s]   = 1;
                pend_dir[s] = m_dir;
                pend_sat[s] = sat;
                for (int d = 0; d < 2; d++) pend_val[d][s] = exp_avg(win[d]);
            end
            m_prev = val;
        end
        k++;
    endtask

    task automatic step(input bit v, input int val, input bit fl);
        valid = v;
        value = 16'(val);
        flush = fl;
        @(posedge clk);
        #1;
        model_edge(v, val, fl);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic async_reset_mid();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs(1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cur;

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        value = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Priming, then a rising step of 88.
        step(1, 100, 0);
        step(1, 188, 0);
        idle(3);
        check("t1_value", 32'(oval0), 32'd319);
        check("t1_dir", 32'(od0), 32'd1);

        // Falling step, then an equal sample keeps the falling direction.
        step(1, 100, 0);
        idle(3);
        check("t2_dir_fall", 32'(od0), 32'd0);
        step(1, 100, 0);
        idle(3);
        check("t2_value_zero", 32'(oval0), 32'd0);

        // Full-scale step clips.
        step(0, 0, 1);
        step(1, 0, 0);
        step(1, 65535, 0);
        idle(3);
        check("t3_sat", 32'(os0), 32'd1);
        check("t3_clip", 32'(oval0), 32'd65535);
        step(1, 65527, 0);
        idle(3);
        check("t3_unsat", 32'(os0), 32'd0);

        // Ramp through the 4-tap window.
        step(0, 0, 1);
        for (int i = 0; i <= 5; i++) step(1, i * 8, 0);
        idle(3);
        check("t4_settled", 32'(oval2), 32'd29);

        // Async reset with samples in flight.
        step(1, 1000, 0);
        step(1, 1300, 0);
        step(1, 900, 0);
        async_reset_mid();
        step(1, 5000, 0);
        idle(4);

        // Flush alongside a valid sample.
        step(1, 7000, 0);
        step(1, 7100, 0);
        step(1, 500, 1);
        step(1, 100, 0);
        step(1, 188, 0);
        idle(3);
        check("t6_value", 32'(oval0), 32'd319);

        // Randomized stream.
        cur = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 65535);
            else cur = (cur + $urandom_range(0, 600) - 300) & 32'hFFFF;
            if (n == 200) async_reset_mid();
            step($urandom_range(0, 9) < 7, cur, $urandom_range(0, 49) == 0);
        end
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
